sap_core: RTL and testbench
===========================

SAP_CORE -- requirements
Module: sap_core

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the accumulator, memory word and output width.
REQ-002 The block SHALL have parameter ADDR_W, default 4, giving the PC and memory address width; DATA_W >= ADDR_W+4 is a legal-configuration constraint.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port mem_addr, output, ADDR_W bits: memory address.
REQ-006 The block SHALL have ports mem_rd and mem_wr, outputs, 1 bit each: read request and write request; never both high.
REQ-007 The block SHALL have port mem_wdata, output, DATA_W bits: write data.
REQ-008 The block SHALL have port mem_rdata, input, DATA_W bits: read data, valid when mem_ready=1.
REQ-009 The block SHALL have port mem_ready, input, 1 bit: completes the current mem_rd or mem_wr at that clock edge.
REQ-010 The block SHALL have ports out_data, output, DATA_W bits, and out_valid, output, 1 bit: output register value and valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: output consumer accept.
REQ-012 The block SHALL have port halted, output, 1 bit: high in HALT state.

Function
REQ-013 Instruction encoding SHALL be opcode = word[DATA_W-1:DATA_W-4], operand = word[ADDR_W-1:0]; opcodes 0 LDA, 1 ADD, 2 SUB, 3 STA, 4 LDI, 5 JMP, 6 JC, 7 JZ, E OUT, F HLT; all others NOP.
REQ-014 The FSM SHALL have states FETCH, DECODE, MEM_RD, MEM_WR, OUT_WAIT, HALT.
REQ-015 FETCH SHALL drive mem_rd=1 with mem_addr=PC, held stable until mem_ready=1; at that edge IR<=mem_rdata, PC<=PC+1 (wrapping 2^ADDR_W-1 to 0), next state DECODE.
REQ-016 DECODE SHALL route LDA/ADD/SUB to MEM_RD, STA to MEM_WR, OUT to OUT_WAIT and HLT to HALT; LDI (ACC<=zero-extended operand), JMP (PC<=operand), JC/JZ (PC<=operand if C/Z set) and NOP SHALL complete in DECODE and return to FETCH.
REQ-017 MEM_RD SHALL drive mem_rd=1 with mem_addr=operand; on mem_ready, LDA sets ACC<=rdata, ADD sets ACC<=ACC+rdata, SUB sets ACC<=ACC-rdata (modulo 2^DATA_W), then next state FETCH.
REQ-018 ADD/SUB SHALL update flags: C = carry-out for ADD, no-borrow (ACC>=rdata) for SUB; Z = (result==0); LDA, LDI and others SHALL leave flags unchanged.
REQ-019 MEM_WR SHALL drive mem_wr=1 with mem_addr=operand and mem_wdata=ACC; on mem_ready, next state FETCH.
REQ-020 OUT_WAIT SHALL drive out_valid=1 with out_data=ACC captured on DECODE exit; on out_ready=1, next state FETCH; out_data SHALL hold its last value afterwards.
REQ-021 HALT SHALL assert halted=1, issue no memory requests, and be left only by rst.
REQ-022 With mem_ready=1 permanently: LDA/ADD/SUB/STA SHALL take 3 cycles, LDI/JMP/JC/JZ/NOP 2 cycles, and OUT 3 cycles when out_ready=1.

Reset
REQ-023 When rst=1 at an edge, the block SHALL set PC=0, ACC=0, IR=0, C=Z=0, out_data=0, state=FETCH, regardless of state, including mid-handshake.
REQ-024 In the cycle after reset, mem_wr, out_valid and halted SHALL be 0, and mem_rd SHALL be 1 with mem_addr=0.

Configuration
REQ-025 With macro SAP_CORE_COND_JUMP_EN defined, JC/JZ and the C/Z flags SHALL be implemented per REQ-016/018; without it, opcodes 6/7 SHALL decode as NOP and the flag registers SHALL be omitted.

Structure
REQ-026 Package sap_core_pkg SHALL hold the opcode constants, OPC_W=4 and the FSM state type.
REQ-027 Sub-module sap_alu SHALL be parametrised by DATA_W and perform add/subtract producing result, carry and zero.

Verification
REQ-028 Program LDA 9 (0x19), ADD A (0x1A), OUT (0xE0), HLT (0xF0) with mem[9]=0x05, mem[A]=0x03 and ready tied high SHALL produce one out_valid pulse with out_data=0x08, then halted=1 at cycle 11.
REQ-029 Program LDI 2, SUB 9 with mem[9]=0x03, then JC 0 SHALL give ACC=0xFF, C=0, Z=0, with the jump not taken (macro defined).
REQ-030 Program LDI 7 (0x47), STA F (0x3F) SHALL produce one mem_wr cycle with mem_addr=0xF and mem_wdata=0x07.
REQ-031 Holding mem_ready=0 for 3 cycles in FETCH SHALL keep mem_rd=1 and mem_addr stable with PC unchanged; holding out_ready=0 for 5 cycles SHALL keep out_valid=1, out_data stable and mem_rd=0.
REQ-032 Executing a NOP at address 0xF SHALL make the next fetch use mem_addr=0x0, showing PC wrap.
REQ-033 Asserting rst during MEM_RD SHALL produce mem_rd=1 with addr 0 the next cycle and ACC=0, and with the macro undefined, JZ SHALL behave as a NOP.

Source files
------------

// File: rtl/sap_core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sap_core_pkg
//  Description : Shared definitions for the SAP accumulator core: opcode
//                width, opcode values and the FSM state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package sap_core_pkg;

  localparam int OPC_W = 4;

  localparam logic [OPC_W-1:0] OP_LDA = 4'h0;
  localparam logic [OPC_W-1:0] OP_ADD = 4'h1;
  localparam logic [OPC_W-1:0] OP_SUB = 4'h2;
  localparam logic [OPC_W-1:0] OP_STA = 4'h3;
  localparam logic [OPC_W-1:0] OP_LDI = 4'h4;
  localparam logic [OPC_W-1:0] OP_JMP = 4'h5;
  localparam logic [OPC_W-1:0] OP_JC  = 4'h6;
  localparam logic [OPC_W-1:0] OP_JZ  = 4'h7;
  localparam logic [OPC_W-1:0] OP_OUT = 4'hE;
  localparam logic [OPC_W-1:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    ST_FETCH    = 3'd0,
    ST_DECODE   = 3'd1,
    ST_MEM_RD   = 3'd2,
    ST_MEM_WR   = 3'd3,
    ST_OUT_WAIT = 3'd4,
    ST_HALT     = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sap_alu.sv
`default_nettype none
// ============================================================================
//  Module      : sap_alu
//  Description : Combinational add/subtract unit for the SAP core.
//  Ports       : i_a, i_b   - operands (DATA_W)
//                i_sub      - 1 selects i_a - i_b, 0 selects i_a + i_b
//                o_result   - result modulo 2^DATA_W
//                o_carry    - carry-out on add, no-borrow (i_a >= i_b) on sub
//                o_zero     - result equals zero
//  Revision    : 1.0 - initial release
// ============================================================================
module sap_alu #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic              i_sub,
  output logic [DATA_W-1:0] o_result,
  output logic              o_carry,
  output logic              o_zero
);

  logic [DATA_W-1:0] w_b_eff;
  logic [DATA_W:0]   w_sum;

  // Subtraction as a + ~b + 1: the carry-out is then exactly "no borrow".
  assign w_b_eff  = i_sub ? ~i_b : i_b;
  assign w_sum    = {1'b0, i_a} + {1'b0, w_b_eff} + {{DATA_W{1'b0}}, i_sub};
  assign o_result = w_sum[DATA_W-1:0];
  assign o_carry  = w_sum[DATA_W];
  assign o_zero   = (w_sum[DATA_W-1:0] == '0);

endmodule
`default_nettype wire

// File: rtl/sap_core.sv
`default_nettype none
// ============================================================================
//  Module      : sap_core
//  Description : Simple-As-Possible accumulator CPU. Fetches instructions
//                over a ready-handshaked memory port, executes LDA/ADD/SUB/
//                STA/LDI/JMP/JC/JZ/OUT/HLT, presents OUT values on a
//                valid/ready output port.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                mem_addr/rd/wr/wdata - memory request (all registered)
//                mem_rdata/mem_ready  - memory response
//                out_data/out_valid   - output register and valid
//                out_ready            - output consumer accept
//                halted               - high in HALT
//  Options     : SAP_CORE_COND_JUMP_EN - implements C/Z flags and JC/JZ;
//                undefined, opcodes 6/7 act as NOP and no flags exist.
//  Revision    : 1.0 - initial release
// ============================================================================
module sap_core
  import sap_core_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              halted
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_ir;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_rd;
  logic              r_mem_wr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid;
  logic              r_halted;

  logic [OPC_W-1:0]  w_opcode;
  logic [ADDR_W-1:0] w_operand;
  logic [DATA_W-1:0] w_imm;
  logic [DATA_W-1:0] w_alu_result;
  logic              w_alu_carry;
  logic              w_alu_zero;
  logic              w_take_jc;
  logic              w_take_jz;
  logic              w_jump;

  assign w_opcode  = r_ir[DATA_W-1 -: OPC_W];
  assign w_operand = r_ir[ADDR_W-1:0];
  assign w_imm     = {{(DATA_W-ADDR_W){1'b0}}, w_operand};

  sap_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .i_a      (r_acc),
    .i_b      (mem_rdata),
    .i_sub    (w_opcode == OP_SUB),
    .o_result (w_alu_result),
    .o_carry  (w_alu_carry),
    .o_zero   (w_alu_zero)
  );

`ifdef SAP_CORE_COND_JUMP_EN
  logic r_c;
  logic r_z;
  assign w_take_jc = r_c;
  assign w_take_jz = r_z;
`else
  // Without conditional jumps the flag outputs of the ALU have no consumer.
  logic w_unused_flags;
  assign w_unused_flags = w_alu_carry ^ w_alu_zero;
  assign w_take_jc      = 1'b0;
  assign w_take_jz      = 1'b0;
`endif

  assign w_jump = (w_opcode == OP_JMP) ||
                  ((w_opcode == OP_JC) && w_take_jc) ||
                  ((w_opcode == OP_JZ) && w_take_jz);

  // All bus/output signals are registered: each transition loads the
  // outputs belonging to the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_FETCH;
      r_pc        <= '0;
      r_acc       <= '0;
      r_ir        <= '0;
      r_mem_addr  <= '0;
      r_mem_rd    <= 1'b1;
      r_mem_wr    <= 1'b0;
      r_mem_wdata <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_halted    <= 1'b0;
`ifdef SAP_CORE_COND_JUMP_EN
      r_c         <= 1'b0;
      r_z         <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (mem_ready) begin
            r_ir     <= mem_rdata;
            r_pc     <= r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
            r_mem_rd <= 1'b0;
            r_state  <= ST_DECODE;
          end
        end

        ST_DECODE: begin
          case (w_opcode)
            OP_LDA, OP_ADD, OP_SUB: begin
              r_mem_rd   <= 1'b1;
              r_mem_addr <= w_operand;
              r_state    <= ST_MEM_RD;
            end
            OP_STA: begin
              r_mem_wr    <= 1'b1;
              r_mem_addr  <= w_operand;
              r_mem_wdata <= r_acc;
              r_state     <= ST_MEM_WR;
            end
            OP_OUT: begin
              r_out_valid <= 1'b1;
              r_out_data  <= r_acc;
              r_state     <= ST_OUT_WAIT;
            end
            OP_HLT: begin
              r_halted <= 1'b1;
              r_state  <= ST_HALT;
            end
            default: begin
              // LDI, jumps and NOP finish here and go straight to fetch.
              if (w_opcode == OP_LDI) begin
                r_acc <= w_imm;
              end
              r_mem_rd <= 1'b1;
              if (w_jump) begin
                r_pc       <= w_operand;
                r_mem_addr <= w_operand;
              end else begin
                r_mem_addr <= r_pc;
              end
              r_state <= ST_FETCH;
            end
          endcase
        end

        ST_MEM_RD: begin
          if (mem_ready) begin
            if (w_opcode == OP_LDA) begin
              r_acc <= mem_rdata;
            end else begin
              r_acc <= w_alu_result;
`ifdef SAP_CORE_COND_JUMP_EN
              r_c   <= w_alu_carry;
              r_z   <= w_alu_zero;
`endif
            end
            // mem_rd stays high: the next fetch follows immediately.
            r_mem_addr <= r_pc;
            r_state    <= ST_FETCH;
          end
        end

        ST_MEM_WR: begin
          if (mem_ready) begin
            r_mem_wr   <= 1'b0;
            r_mem_rd   <= 1'b1;
            r_mem_addr <= r_pc;
            r_state    <= ST_FETCH;
          end
        end

        ST_OUT_WAIT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_mem_rd    <= 1'b1;
            r_mem_addr  <= r_pc;
            r_state     <= ST_FETCH;
          end
        end

        ST_HALT: begin
          r_halted <= 1'b1;
        end

        default: begin
          r_mem_rd   <= 1'b1;
          r_mem_wr   <= 1'b0;
          r_mem_addr <= r_pc;
          r_state    <= ST_FETCH;
        end
      endcase
    end
  end

  assign mem_addr  = r_mem_addr;
  assign mem_rd    = r_mem_rd;
  assign mem_wr    = r_mem_wr;
  assign mem_wdata = r_mem_wdata;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign halted    = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_sap_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sap_core
//  Description : Directed self-checking bench for sap_core with a 16-word
//                behavioural memory. Conditional-jump expectations follow
//                SAP_CORE_COND_JUMP_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sap_core;

  logic       clk;
  logic       rst;
  logic [3:0] mem_addr;
  logic       mem_rd;
  logic       mem_wr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       mem_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       halted;

  logic [7:0] mem [16];

  int total;
  int bad;

`ifdef SAP_CORE_COND_JUMP_EN
  localparam logic [7:0] EXP_JZ_OUT = 8'h0A;
  localparam logic [7:0] EXP_JC_OUT = 8'h0A;
`else
  localparam logic [7:0] EXP_JZ_OUT = 8'h00;
  localparam logic [7:0] EXP_JC_OUT = 8'h01;
`endif

  sap_core #(
    .DATA_W (8),
    .ADDR_W (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb mem_rdata = mem[mem_addr];

  // Read and write requests must never coexist.
  always @(negedge clk) begin
    if (!rst) begin
      total++;
      if (mem_rd && mem_wr) begin
        bad++;
        $display("FAIL rd_wr_exclusive: mem_rd=%0b mem_wr=%0b required not both", mem_rd, mem_wr);
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
  endtask

  // Leaves the bench at the negedge of cycle 0 (first cycle after reset).
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_prog(input int budget, output int n_out, output logic [7:0] last_out,
                          output int out_cyc, output int halt_cyc, output int n_wr,
                          output logic [3:0] wr_addr, output logic [7:0] wr_data);
    n_out = 0; last_out = 8'h00; out_cyc = -1; halt_cyc = -1;
    n_wr = 0; wr_addr = 4'h0; wr_data = 8'h00;
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (halted) begin
        halt_cyc = cyc;
        break;
      end
      if (out_valid && out_ready) begin
        n_out++;
        last_out = out_data;
        if (out_cyc < 0) out_cyc = cyc;
      end
      if (mem_wr && mem_ready) begin
        n_wr++;
        wr_addr = mem_addr;
        wr_data = mem_wdata;
        mem[mem_addr] = mem_wdata;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_basic();
    int n_out, out_cyc, halt_cyc, n_wr;
    logic [7:0] last_out, wr_data;
    logic [3:0] wr_addr;
    clear_mem();
    mem[0] = 8'h19; mem[1] = 8'h1A; mem[2] = 8'hE0; mem[3] = 8'hF0;
    mem[9] = 8'h05; mem[10] = 8'h03;
    mem_ready = 1'b1; out_ready = 1'b1;
    do_reset();
    run_prog(40, n_out, last_out, out_cyc, halt_cyc, n_wr, wr_addr, wr_data);
    total++; if (n_out !== 1) begin bad++; $display("FAIL basic_out_count: got %0d want 1", n_out); end
    total++; if (last_out !== 8'h08) begin bad++; $display("FAIL basic_out_data: got %h want 08", last_out); end
    total++; if (out_cyc !== 8) begin bad++; $display("FAIL basic_out_cycle: got %0d want 8", out_cyc); end
    total++; if (halt_cyc !== 11) begin bad++; $display("FAIL basic_halt_cycle: got %0d want 11", halt_cyc); end
    repeat (3) @(negedge clk);
    total++;
    if (mem_rd !== 1'b0 || mem_wr !== 1'b0 || halted !== 1'b1) begin
      bad++;
      $display("FAIL halt_quiet: rd=%b wr=%b halted=%b want 0 0 1", mem_rd, mem_wr, halted);
    end
  endtask

  task automatic test_reset();
    // Entered from HALT with out_data holding 0x08.
    do_reset();
    total++;
    if (halted !== 1'b0 || out_valid !== 1'b0 || mem_wr !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags: halted=%b out_valid=%b mem_wr=%b want 0 0 0", halted, out_valid, mem_wr);
    end
    total++;
    if (mem_rd !== 1'b1 || mem_addr !== 4'h0) begin
      bad++;
      $display("FAIL reset_fetch: mem_rd=%b addr=%h want 1 0", mem_rd, mem_addr);
    end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data: got %h want 00", out_data); end
  endtask

  task automatic test_sub_jc();
    int n_out, out_cyc, halt_cyc, n_wr;
    logic [7:0] last_out, wr_data;
    logic [3:0] wr_addr;
    clear_mem();
    mem[0] = 8'h42; mem[1] = 8'h29; mem[2] = 8'h60; mem[3] = 8'hE0; mem[4] = 8'hF0;
    mem[9] = 8'h03;
    do_reset();
    run_prog(60, n_out, last_out, out_cyc, halt_cyc, n_wr, wr_addr, wr_data);
    total++; if (n_out !== 1) begin bad++; $display("FAIL sub_out_count: got %0d want 1", n_out); end
    total++; if (last_out !== 8'hFF) begin bad++; $display("FAIL sub_result: got %h want ff", last_out); end
    total++; if (halt_cyc !== 12) begin bad++; $display("FAIL sub_jc_halt_cycle: got %0d want 12", halt_cyc); end
  endtask

  task automatic test_jz_zero();
    int n_out, out_cyc, halt_cyc, n_wr;
    logic [7:0] last_out, wr_data;
    logic [3:0] wr_addr;
    clear_mem();
    mem[0] = 8'h43; mem[1] = 8'h29; mem[2] = 8'h76; mem[3] = 8'hE0; mem[4] = 8'hF0;
    mem[6] = 8'h4A; mem[7] = 8'hE0; mem[8] = 8'hF0; mem[9] = 8'h03;
    do_reset();
    run_prog(60, n_out, last_out, out_cyc, halt_cyc, n_wr, wr_addr, wr_data);
    total++; if (n_out !== 1) begin bad++; $display("FAIL jz_out_count: got %0d want 1", n_out); end
    total++; if (last_out !== EXP_JZ_OUT) begin bad++; $display("FAIL jz_path: got %h want %h", last_out, EXP_JZ_OUT); end
  endtask

  task automatic test_add_carry_jc();
    int n_out, out_cyc, halt_cyc, n_wr;
    logic [7:0] last_out, wr_data;
    logic [3:0] wr_addr;
    clear_mem();
    mem[0] = 8'h45; mem[1] = 8'h19; mem[2] = 8'h66; mem[3] = 8'hE0; mem[4] = 8'hF0;
    mem[6] = 8'h4A; mem[7] = 8'hE0; mem[8] = 8'hF0; mem[9] = 8'hFC;
    do_reset();
    run_prog(60, n_out, last_out, out_cyc, halt_cyc, n_wr, wr_addr, wr_data);
    total++; if (last_out !== EXP_JC_OUT) begin bad++; $display("FAIL jc_carry_path: got %h want %h", last_out, EXP_JC_OUT); end
  endtask

  task automatic test_sta();
    int n_out, out_cyc, halt_cyc, n_wr;
    logic [7:0] last_out, wr_data;
    logic [3:0] wr_addr;
    clear_mem();
    mem[0] = 8'h47; mem[1] = 8'h3F; mem[2] = 8'hF0;
    do_reset();
    run_prog(40, n_out, last_out, out_cyc, halt_cyc, n_wr, wr_addr, wr_data);
    total++; if (n_wr !== 1) begin bad++; $display("FAIL sta_wr_count: got %0d want 1", n_wr); end
    total++; if (wr_addr !== 4'hF) begin bad++; $display("FAIL sta_addr: got %h want f", wr_addr); end
    total++; if (wr_data !== 8'h07) begin bad++; $display("FAIL sta_data: got %h want 07", wr_data); end
    total++; if (mem[15] !== 8'h07) begin bad++; $display("FAIL sta_mem: got %h want 07", mem[15]); end
    total++; if (halt_cyc !== 7) begin bad++; $display("FAIL sta_halt_cycle: got %0d want 7", halt_cyc); end
  endtask

  task automatic test_stall();
    bit seen;
    clear_mem();
    mem[0] = 8'h19; mem[1] = 8'h1A; mem[2] = 8'hE0; mem[3] = 8'hF0;
    mem[9] = 8'h05; mem[10] = 8'h03;
    mem_ready = 1'b0; out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (mem_rd !== 1'b1 || mem_addr !== 4'h0) begin
        bad++;
        $display("FAIL fetch_stall_%0d: rd=%b addr=%h want 1 0", i, mem_rd, mem_addr);
      end
      if (i == 3) mem_ready = 1'b1;
      @(negedge clk);
    end
    total++; if (mem_rd !== 1'b0) begin bad++; $display("FAIL stall_decode_rd: got %b want 0", mem_rd); end
    @(negedge clk);
    total++;
    if (mem_rd !== 1'b1 || mem_addr !== 4'h9) begin
      bad++;
      $display("FAIL stall_memrd: rd=%b addr=%h want 1 9", mem_rd, mem_addr);
    end
    @(negedge clk);
    total++;
    if (mem_rd !== 1'b1 || mem_addr !== 4'h1) begin
      bad++;
      $display("FAIL stall_pc: rd=%b addr=%h want 1 1", mem_rd, mem_addr);
    end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    total++; if (!seen) begin bad++; $display("FAIL out_wait_timeout: out_valid=0 want 1"); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== 8'h08 || mem_rd !== 1'b0) begin
        bad++;
        $display("FAIL out_stall_%0d: valid=%b data=%h rd=%b want 1 08 0", i, out_valid, out_data, mem_rd);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || out_data !== 8'h08 || mem_rd !== 1'b1 || mem_addr !== 4'h3) begin
      bad++;
      $display("FAIL out_release: valid=%b data=%h rd=%b addr=%h want 0 08 1 3",
               out_valid, out_data, mem_rd, mem_addr);
    end
  endtask

  task automatic test_pc_wrap();
    clear_mem();
    mem[0] = 8'h5F; mem[15] = 8'hD0;
    mem_ready = 1'b1; out_ready = 1'b1;
    do_reset();
    repeat (2) @(negedge clk);
    total++;
    if (mem_rd !== 1'b1 || mem_addr !== 4'hF) begin
      bad++;
      $display("FAIL jmp_target: rd=%b addr=%h want 1 f", mem_rd, mem_addr);
    end
    repeat (2) @(negedge clk);
    total++;
    if (mem_rd !== 1'b1 || mem_addr !== 4'h0) begin
      bad++;
      $display("FAIL pc_wrap: rd=%b addr=%h want 1 0", mem_rd, mem_addr);
    end
  endtask

  task automatic test_reset_mid_memrd();
    clear_mem();
    mem[0] = 8'h19; mem[1] = 8'h1A; mem[2] = 8'hE0; mem[3] = 8'hF0;
    mem[9] = 8'h05; mem[10] = 8'h03;
    mem_ready = 1'b1; out_ready = 1'b1;
    do_reset();
    repeat (4) @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    total++;
    if (mem_rd !== 1'b1 || mem_addr !== 4'hA) begin
      bad++;
      $display("FAIL mid_memrd_state: rd=%b addr=%h want 1 a", mem_rd, mem_addr);
    end
    rst = 1'b1;
    mem[0] = 8'hE0; mem[1] = 8'hF0;
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b1;
    total++;
    if (mem_rd !== 1'b1 || mem_addr !== 4'h0) begin
      bad++;
      $display("FAIL mid_reset_fetch: rd=%b addr=%h want 1 0", mem_rd, mem_addr);
    end
    repeat (2) @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'h00) begin
      bad++;
      $display("FAIL mid_reset_acc: valid=%b data=%h want 1 00", out_valid, out_data);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    mem_ready = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    test_basic();
    test_reset();
    test_sub_jc();
    test_jz_zero();
    test_add_carry_jc();
    test_sta();
    test_stall();
    test_pc_wrap();
    test_reset_mid_memrd();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
